mlp_train_sequencer: RTL and testbench

// - Hardware driver for the MLP core. Replaces the hand-written training loop with synthesizable sequencing.
// - Holds a sample table of inputs and expected outputs.
// - Per epoch: one training pass (training=1, one sample per cycle), then one evaluation pass (training=0).
// - Scores each prediction against HALF and reports correct-classification counts. Output ports wire straight to the MLP.

---
 rtl/mlp_train_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mlp_train_sequencer.sv
// Training/evaluation sequencer for the MLP core: replays a sample table, scores eval predictions.
// Optional: define MLP_SEQ_EARLY_STOP_EN to end the run after the first fully correct eval pass.

module mlp_seq_lane #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic [DATA_W-1:0] pred,
  input  logic [DATA_W-1:0] tgt,
  output logic              hit
);
  localparam logic signed [DATA_W-1:0] HALF = DATA_W'(1 << (FRAC_W - 1));

  assign hit = ($signed(pred) < HALF) == ($signed(tgt) < HALF);
endmodule

module mlp_train_sequencer #(
  parameter int INPUTS       = 2,
  parameter int OUTPUTS      = 1,
  parameter int NUM_SAMPLES  = 4,
  parameter int PRED_LATENCY = 1,
  parameter int EPOCH_W      = 16,
  parameter int DATA_W       = 16,
  parameter int FRAC_W       = 8,
  localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int CW = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_we,
  input  logic [AW-1:0]                    cfg_addr,
  input  logic [INPUTS-1:0][DATA_W-1:0]    cfg_values,
  input  logic [OUTPUTS-1:0][DATA_W-1:0]   cfg_expected,
  input  logic                             start,
  input  logic [EPOCH_W-1:0]               num_epochs,
  input  logic [OUTPUTS-1:0][DATA_W-1:0]   prediction,
  output logic [INPUTS-1:0][DATA_W-1:0]    values,
  output logic [OUTPUTS-1:0][DATA_W-1:0]   expected,
  output logic                             training,
  output logic                             busy,
  output logic                             done,
  output logic [EPOCH_W-1:0]               epoch,
  output logic [CW-1:0]                    last_correct
);
  localparam int STAGES = PRED_LATENCY - 1;
  localparam int LW     = $clog2(PRED_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, TRAIN, EVAL, DRAIN, FIN} state_t;

  state_t                           state, nxt;
  logic [AW-1:0]                    smp, row;
  logic [LW-1:0]                    dcnt;
  logic [EPOCH_W-1:0]               n_ep;
  logic [EPOCH_W:0]                 ep_inc;
  logic [CW-1:0]                    run_cnt, cnt_nx;
  logic                             last_smp, drain_end, more_ep, all_ok, sample_ok;
  logic [OUTPUTS-1:0]               hit;
  logic [STAGES:0]                  vld_pipe;
  logic [OUTPUTS-1:0][DATA_W-1:0]   exp_pipe [0:STAGES];

  logic [INPUTS-1:0][DATA_W-1:0]    tbl_v [NUM_SAMPLES];
  logic [OUTPUTS-1:0][DATA_W-1:0]   tbl_e [NUM_SAMPLES];

  // Table is intentionally not reset; it only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE && int'(cfg_addr) < NUM_SAMPLES) begin
      tbl_v[cfg_addr] <= cfg_values;
      tbl_e[cfg_addr] <= cfg_expected;
    end
  end

  assign last_smp  = (smp == AW'(NUM_SAMPLES - 1));
  assign drain_end = (dcnt == LW'(PRED_LATENCY - 1));
  assign ep_inc    = {1'b0, epoch} + (EPOCH_W+1)'(1);
  assign more_ep   = ep_inc < {1'b0, n_ep};
  assign row       = (state == DRAIN) ? AW'(NUM_SAMPLES - 1) : smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    busy     = 1'b0;
    done     = 1'b0;
    training = 1'b0;
    values   = '0;
    expected = '0;
    case (state)
      IDLE:  if (start) nxt = (num_epochs == '0) ? EVAL : TRAIN;
      TRAIN: begin
        busy     = 1'b1;
        training = 1'b1;
        if (last_smp) nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (last_smp) nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_end) nxt = (more_ep && !all_ok) ? TRAIN : FIN;
      end
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (busy) begin
      values   = tbl_v[row];
      expected = tbl_e[row];
    end
  end

  // Expected rows and eval tags travel alongside the MLP latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k <= STAGES; k++) exp_pipe[k] <= '0;
    end else begin
      vld_pipe[0] <= (state == EVAL);
      exp_pipe[0] <= expected;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        exp_pipe[k] <= exp_pipe[k-1];
      end
    end
  end

  for (genvar j = 0; j < OUTPUTS; j++) begin : g_lane
    mlp_seq_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
      .pred (prediction[j]),
      .tgt  (exp_pipe[STAGES][j]),
      .hit  (hit[j])
    );
  end

  assign sample_ok = &hit;
  assign cnt_nx    = run_cnt + CW'(vld_pipe[STAGES] & sample_ok);

`ifdef MLP_SEQ_EARLY_STOP_EN
  assign all_ok = (cnt_nx == CW'(NUM_SAMPLES));
`else
  assign all_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp          <= '0;
      dcnt         <= '0;
      n_ep         <= '0;
      epoch        <= '0;
      run_cnt      <= '0;
      last_correct <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_ep  <= num_epochs;
        epoch <= '0;
      end
      smp  <= ((state == TRAIN || state == EVAL) && !last_smp) ? smp + AW'(1) : '0;
      dcnt <= (state == DRAIN && !drain_end) ? dcnt + LW'(1) : '0;
      if (state == DRAIN && drain_end) begin
        last_correct <= cnt_nx;
        if (nxt == TRAIN) epoch <= epoch + EPOCH_W'(1);
      end
      run_cnt <= (nxt == EVAL && state != EVAL) ? '0 : cnt_nx;
    end
  end
endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Randomized bench for mlp_train_sequencer: two DUTs (latency 1 and 3) against a trace model.

module tb_mlp_train_sequencer;
  localparam int IN = 2, OUT = 1, NS = 4, DW = 16, EW = 16;
  localparam logic [DW-1:0] ONE = 16'h0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    sel;          // 0: latency-1 DUT, 1: latency-3 DUT
  int                      mode;         // stub: 0 constant ONE, 1 echo, 2 negate
  logic                    cfg_we, start;
  logic [1:0]              cfg_addr;
  logic [IN-1:0][DW-1:0]   cfg_values;
  logic [OUT-1:0][DW-1:0]  cfg_expected;
  logic [EW-1:0]           num_epochs;

  logic [OUT-1:0][DW-1:0]  pred_a, pred_b, exp_a, exp_b;
  logic [IN-1:0][DW-1:0]   val_a, val_b;
  logic                    trn_a, trn_b, busy_a, busy_b, done_a, done_b;
  logic [EW-1:0]           ep_a, ep_b;
  logic [2:0]              lc_a, lc_b;

  mlp_train_sequencer #(.PRED_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we & ~sel), .cfg_addr(cfg_addr),
    .cfg_values(cfg_values), .cfg_expected(cfg_expected), .start(start & ~sel),
    .num_epochs(num_epochs), .prediction(pred_a), .values(val_a), .expected(exp_a),
    .training(trn_a), .busy(busy_a), .done(done_a), .epoch(ep_a), .last_correct(lc_a));

  mlp_train_sequencer #(.PRED_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we & sel), .cfg_addr(cfg_addr),
    .cfg_values(cfg_values), .cfg_expected(cfg_expected), .start(start & sel),
    .num_epochs(num_epochs), .prediction(pred_b), .values(val_b), .expected(exp_b),
    .training(trn_b), .busy(busy_b), .done(done_b), .epoch(ep_b), .last_correct(lc_b));

  // Stub MLPs: prediction is a fixed function of the expected row, delayed by the latency.
  function automatic logic [DW-1:0] stub(input logic [DW-1:0] e);
    case (mode)
      0:       return ONE;
      1:       return e;
      default: return -e;
    endcase
  endfunction

  logic [DW-1:0] dl_a;
  logic [DW-1:0] dl_b [3];
  always @(posedge clk) begin
    dl_a    <= exp_a[0];
    dl_b[0] <= exp_b[0];
    dl_b[1] <= dl_b[0];
    dl_b[2] <= dl_b[1];
  end
  assign pred_a[0] = stub(dl_a);
  assign pred_b[0] = stub(dl_b[2]);

  logic [127:0] obs;
  logic [2:0]   o_lc;
  assign obs  = sel ? {trn_b, busy_b, done_b, val_b, exp_b, ep_b}
                    : {trn_a, busy_a, done_a, val_a, exp_a, ep_a};
  assign o_lc = sel ? lc_b : lc_a;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [2*DW-1:0] tbl_v [2][NS];
  logic [DW-1:0]   tbl_e [2][NS];

  function automatic bit ok(input logic [DW-1:0] e);
    logic [DW-1:0] p;
    p = stub(e);
    return ((int'($signed(p)) < 128) == (int'($signed(e)) < 128));
  endfunction

  function automatic logic [127:0] pack(input bit trn, input bit b, input bit d,
                                        input int r, input int ep);
    logic [2*DW-1:0] v;
    logic [DW-1:0]   e;
    v = (r < 0) ? '0 : tbl_v[sel][r];
    e = (r < 0) ? '0 : tbl_e[sel][r];
    return {61'd0, trn, b, d, v, e, EW'(ep)};
  endfunction

  task automatic write_row(input int a, input logic [2*DW-1:0] v, input logic [DW-1:0] e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_values = v; cfg_expected = e;
    tbl_v[sel][a] = v; tbl_e[sel][a] = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One run: build the cycle-by-cycle trace from the sequencing rules, then compare.
  task automatic run(input int ne, input bit poke, input bit wr0);
    logic [127:0] q[$];
    int L, eff, cc;
    L = sel ? 3 : 1;
    @(negedge clk);
    if (wr0) begin
      cfg_we = 1'b1; cfg_addr = 2'd0;
      cfg_values = {16'($urandom), 16'($urandom)}; cfg_expected = 16'($urandom);
      tbl_v[sel][0] = cfg_values; tbl_e[sel][0] = cfg_expected;
    end
    start = 1'b1; num_epochs = EW'(ne);
    cc = 0;
    for (int r = 0; r < NS; r++) if (ok(tbl_e[sel][r])) cc++;
    eff = (ne == 0) ? 1 : ne;
`ifdef MLP_SEQ_EARLY_STOP_EN
    if (cc == NS) eff = 1;
`endif
    for (int e = 0; e < eff; e++) begin
      if (ne != 0) for (int r = 0; r < NS; r++) q.push_back(pack(1, 1, 0, r, e));
      for (int r = 0; r < NS; r++) q.push_back(pack(0, 1, 0, r, e));
      for (int d = 0; d < L; d++) q.push_back(pack(0, 1, 0, NS - 1, e));
    end
    q.push_back(pack(0, 0, 1, -1, eff - 1));
    q.push_back(pack(0, 0, 0, -1, eff - 1));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      chk($sformatf("cyc%0d", i), obs, q[i]);
      if (poke && i == 2) begin
        cfg_we = 1'b1; cfg_addr = 2'd0;
        cfg_values = {16'($urandom), 16'($urandom)}; cfg_expected = 16'($urandom);
        start = 1'b1; num_epochs = 16'd7;
      end
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    chk("last_correct", 128'(o_lc), 128'(cc));
  endtask

  initial begin
    sel = 1'b0; mode = 0; cfg_we = 1'b0; start = 1'b0;
    cfg_addr = '0; cfg_values = '0; cfg_expected = '0; num_epochs = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {obs, 125'(o_lc)}, '0);
    rst_n = 1'b1;

    // Test 1: XOR table, constant-ONE stub, three epochs (also loads the latency-3 table)
    for (int s = 1; s >= 0; s--) begin
      sel = s[0];
      write_row(0, {16'h0, 16'h0}, 16'h0);
      write_row(1, {ONE,   16'h0}, ONE);
      write_row(2, {16'h0, ONE},   ONE);
      write_row(3, {ONE,   ONE},   16'h0);
    end
    run(3, 0, 0);

    // Test 2: zero epochs gives a single eval pass
    run(0, 0, 0);

    // Test 3: writes and start while busy are dropped; then a write coinciding with start
    mode = 2;
    run(2, 1, 0);
    run(1, 0, 0);
    run(1, 0, 1);

    // Test 4: asynchronous reset during epoch-1 eval
    @(negedge clk);
    start = 1'b1; num_epochs = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_eval", {126'd0, trn_a, busy_a}, 128'b01);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {obs, 125'(o_lc)}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_no_done", {126'd0, done_a, busy_a}, '0);
    end
    run(2, 0, 0);

    // Test 5: latency 3, echo stub
    sel = 1'b1; mode = 1;
    run(2, 0, 0);

    // Test 6: echo stub, many epochs (stops early only with the early-stop build)
    sel = 1'b0;
    run(100, 0, 0);

    // Randomized tables, stubs, epochs and DUT selection
    for (int it = 0; it < 10; it++) begin
      sel  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      for (int r = 0; r < NS; r++) begin
        logic [DW-1:0] e;
        case ($urandom_range(0, 4))
          0: e = 16'h0000;
          1: e = ONE;
          2: e = 16'h0080;
          3: e = 16'h007f;
          default: e = 16'($urandom);
        endcase
        if ($urandom_range(0, 3) != 0) write_row(r, {16'($urandom), 16'($urandom)}, e);
      end
      run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
